serial_adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one bit-serial adder among up to N_REQ requesters. It picks one pending requester, captures that requester's operands, and runs SIZE bit-serial add cycles (LSB first, with a registered carry). It then returns a SIZE+1-bit sum tagged with the requester index. It sits between multiple client blocks and the serial-add datapath, replacing per-client START/LOAD sequencing.

---
 rtl/serial_adder_arbiter.sv | 138 +++++++++++++
 tb/tb_serial_adder_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/serial_adder_arbiter.sv
// Round-robin front end for one shared bit-serial adder: grants one requester,
// captures its operands, adds LSB-first over SIZE cycles and returns a tagged sum.
module serial_adder_arbiter #(
    parameter int SIZE  = 8,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        REQ,
    input  logic [N_REQ*SIZE-1:0]   A_IN,
    input  logic [N_REQ*SIZE-1:0]   B_IN,
    output logic [N_REQ-1:0]        GNT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [ID_W-1:0]         DONE_ID,
    output logic [SIZE:0]           SUM
);
    localparam int CNT_W = $clog2(SIZE + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [SIZE-1:0]     a_q, a_d, b_q, b_d, psum_q, psum_d;
    logic                c_q, c_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [SIZE:0]       sum_q, sum_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;

    logic                found;
    logic [ID_W-1:0]     win;
    int                  pos;
    logic                s_bit, c_bit;
    logic                last;

    // Search order ptr, ptr+1, ... wrapping at N_REQ; first pending index wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && REQ[i] && (i == pos)) begin
                    found = 1'b1;
                    win   = ID_W'(i);
                end
            end
        end
    end

    assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
    assign c_bit = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    assign last  = (cnt_q == CNT_W'(SIZE - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            psum_q    <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            sum_q     <= '0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            psum_q    <= psum_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            sum_q     <= sum_d;
            done_id_q <= done_id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (found) state_d = S_SHIFT;
            S_SHIFT: if (last)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        psum_d    = psum_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        sum_d     = sum_q;
        done_id_d = done_id_q;
        if (state_q == S_IDLE && found) begin
            a_d        = A_IN[win*SIZE +: SIZE];
            b_d        = B_IN[win*SIZE +: SIZE];
            psum_d     = '0;
            c_d        = 1'b0;
            cnt_d      = '0;
            id_d       = win;
            gnt_d[win] = 1'b1;
            ptr_d      = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
        end else if (state_q == S_SHIFT) begin
            psum_d = {s_bit, psum_q[SIZE-1:1]};
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            c_d    = c_bit;
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
                sum_d     = {c_bit, s_bit, psum_q[SIZE-1:1]};
                done_id_d = id_q;
            end
        end
    end

    always_comb begin
        GNT     = gnt_q;
        BUSY    = (state_q != S_IDLE);
        DONE    = (state_q == S_DONE);
        SUM     = sum_q;
        DONE_ID = done_id_q;
    end
endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Directed bench for serial_adder_arbiter: reset, sums, width edges,
// round-robin order, withdrawn request and mid-add reset.
module tb_serial_adder_arbiter;
    localparam int SIZE  = 8;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [N_REQ-1:0]      REQ;
    logic [N_REQ*SIZE-1:0] A_IN, B_IN;
    logic [N_REQ-1:0]      GNT;
    logic                  BUSY, DONE;
    logic [ID_W-1:0]       DONE_ID;
    logic [SIZE:0]         SUM;

    int n_assert = 0;
    int n_fail   = 0;

    serial_adder_arbiter #(.SIZE(SIZE), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .A_IN(A_IN), .B_IN(B_IN),
        .GNT(GNT), .BUSY(BUSY), .DONE(DONE), .DONE_ID(DONE_ID), .SUM(SUM)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        A_IN[i*SIZE +: SIZE] = a;
        B_IN[i*SIZE +: SIZE] = b;
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic run_op(input string tag, input logic [3:0] req, input logic [3:0] exp_gnt,
                          input logic [1:0] exp_id, input logic [8:0] exp_sum);
        logic [8:0] prev_sum;
        prev_sum = SUM;
        REQ = req;
        tick();
        chk({tag, " gnt"}, GNT, exp_gnt);
        chk({tag, " busy c1"}, BUSY, 1'b1);
        REQ = '0;
        for (int k = 2; k <= SIZE; k++) begin
            tick();
            chk({tag, " gnt low"}, GNT, 4'b0000);
            chk({tag, " busy shift"}, BUSY, 1'b1);
            chk({tag, " no early done"}, DONE, 1'b0);
            chk({tag, " sum stable"}, SUM, prev_sum);
        end
        tick();
        chk({tag, " done"}, DONE, 1'b1);
        chk({tag, " busy done"}, BUSY, 1'b1);
        chk({tag, " sum"}, SUM, exp_sum);
        chk({tag, " id"}, DONE_ID, exp_id);
        tick();
        chk({tag, " idle busy"}, BUSY, 1'b0);
        chk({tag, " idle done"}, DONE, 1'b0);
        chk({tag, " sum held"}, SUM, exp_sum);
    endtask

    initial begin
        RST  = 1'b1;
        REQ  = 4'b1111;
        A_IN = '0;
        B_IN = '0;

        // Reset held two cycles with all requests up.
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst gnt", GNT, 4'b0000);
            chk("rst busy", BUSY, 1'b0);
            chk("rst done", DONE, 1'b0);
            chk("rst sum", SUM, 9'h000);
            chk("rst id", DONE_ID, 2'd0);
        end
        RST = 1'b0;
        REQ = 4'b0000;
        tick();
        chk("post rst gnt", GNT, 4'b0000);
        chk("post rst busy", BUSY, 1'b0);

        // Single op and width edges, one requester each.
        set_ops(0, 8'h5A, 8'h3C);
        set_ops(1, 8'hFF, 8'hFF);
        set_ops(2, 8'h00, 8'h00);
        set_ops(3, 8'h80, 8'h80);
        run_op("single", 4'b0001, 4'b0001, 2'd0, 9'h096);
        run_op("ff+ff",  4'b0010, 4'b0010, 2'd1, 9'h1FE);
        run_op("00+00",  4'b0100, 4'b0100, 2'd2, 9'h000);
        run_op("80+80",  4'b1000, 4'b1000, 2'd3, 9'h100);

        // Request pulse that never meets a rising edge.
        @(negedge CLK);
        REQ = 4'b0010;
        #2;
        REQ = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("withdraw gnt", GNT, 4'b0000);
            chk("withdraw busy", BUSY, 1'b0);
        end

        // Round-robin: ptr is 0 here.
        set_ops(0, 8'h01, 8'h02);
        set_ops(1, 8'h7F, 8'h01);
        set_ops(2, 8'hC3, 8'h5A);
        set_ops(3, 8'hAA, 8'h55);
        run_op("rr0",  4'b1111, 4'b0001, 2'd0, 9'h003);
        run_op("rr1",  4'b1111, 4'b0010, 2'd1, 9'h080);
        run_op("rr2",  4'b1111, 4'b0100, 2'd2, 9'h11D);
        run_op("rr3",  4'b1111, 4'b1000, 2'd3, 9'h0FF);
        run_op("rr0b", 4'b1111, 4'b0001, 2'd0, 9'h003);
        run_op("g2",   4'b0100, 4'b0100, 2'd2, 9'h11D);
        run_op("wrap", 4'b0101, 4'b0001, 2'd0, 9'h003);

        // Abort requester 1 in c4; ptr would otherwise have moved to 2.
        REQ = 4'b0010;
        tick();
        chk("abort gnt", GNT, 4'b0010);
        REQ = 4'b0000;
        tick();
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort busy", BUSY, 1'b0);
        chk("abort sum", SUM, 9'h000);
        chk("abort done", DONE, 1'b0);
        chk("abort id", DONE_ID, 2'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("abort no done", DONE, 1'b0);
            chk("abort idle", BUSY, 1'b0);
        end
        run_op("ptr reset", 4'b0110, 4'b0010, 2'd1, 9'h080);
        run_op("after rst", 4'b0100, 4'b0100, 2'd2, 9'h11D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
